// File: rtl/disp_pkg.sv
// Shared display types and constants for the binary-to-BCD converter.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGITS_DEFAULT = 6;
  localparam int BIN_W_DEFAULT  = 20;

  // Largest value representable in the given number of BCD digits (10^digits - 1).
  function automatic logic [63:0] bcd_max(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus between a value producer and the converter.
interface bin_to_bcd_seq_if
  import disp_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     blank;
  logic                  ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, blank, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, blank, ovf
  );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: adds 3 to a BCD nibble of 5 or more. Purely combinational.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble: one bit per clock, done pulses BIN_W+1 cycles after start is accepted.
// start is ignored while busy; results hold until the next done pulse.
module bin_to_bcd_seq
  import disp_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
)(
  input  logic              Clk,
  input  logic              Reset_n,
  bin_to_bcd_seq_if.slave   bus
);
  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          SW      = BCD_W + BIN_W;
  localparam int          CW      = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_VAL = bcd_max(DIGITS);

  state_t             state;
  logic [SW-1:0]      scratch;
  logic [SW-1:0]      adjusted;
  logic [CW-1:0]      count;
  logic [BIN_W-1:0]   latched;
  logic [BCD_W-1:0]   bcd_fin;
  logic [DIGITS-1:0]  blank_fin;
  logic               ovf_fin;
  logic               zero_run;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .nib (scratch[BIN_W + 4*g +: 4]),
      .adj (adjusted[BIN_W + 4*g +: 4])
    );
  end
  assign adjusted[BIN_W-1:0] = scratch[BIN_W-1:0];

  // Overflow is judged on the original binary; the BCD field may have lost carries.
  assign ovf_fin = 64'(latched) > MAX_VAL;
  assign bcd_fin = ovf_fin ? {DIGITS{4'h9}} : scratch[SW-1:BIN_W];

  always_comb begin
    blank_fin = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (bcd_fin[4*i +: 4] == 4'd0);
      blank_fin[i] = zero_run & ~ovf_fin;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= IDLE;
      scratch     <= '0;
      count       <= '0;
      latched     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bcd_out <= '0;
      bus.blank   <= {{(DIGITS-1){1'b1}}, 1'b0};
      bus.ovf     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            scratch  <= {{BCD_W{1'b0}}, bus.bin_in};
            latched  <= bus.bin_in;
            count    <= CW'(BIN_W);
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adjusted[SW-2:0], 1'b0};
          count   <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bus.bcd_out <= bcd_fin;
          bus.blank   <= blank_fin;
          bus.ovf     <= ovf_fin;
          bus.done    <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed-vector bench for bin_to_bcd_seq with default parameters (20-bit input, 6 digits).
module tb_bin_to_bcd_seq;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bin_to_bcd_seq_if #(.BIN_W(20), .DIGITS(6)) bus ();

  bin_to_bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start with v, scramble bin_in afterwards, and return cycles until done (-1 on timeout).
  task automatic do_conv(input logic [19:0] v, output int lat);
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bin_in = 20'hABCDE;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.bcd_out !== 24'h000000) begin bad++; $display("FAIL reset_bcd got=%h want=000000", bus.bcd_out); end
    total++; if (bus.blank !== 6'b111110) begin bad++; $display("FAIL reset_blank got=%b want=111110", bus.blank); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    do_conv(20'd123456, lat);
    total++; if (lat != 21) begin bad++; $display("FAIL basic_latency got=%0d want=21", lat); end
    total++; if (bus.bcd_out !== 24'h123456) begin bad++; $display("FAIL basic_bcd got=%h want=123456", bus.bcd_out); end
    total++; if (bus.blank !== 6'b000000) begin bad++; $display("FAIL basic_blank got=%b want=000000", bus.blank); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", bus.ovf); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_in_done got=%b want=0", bus.busy); end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", bus.done); end
    total++; if (bus.bcd_out !== 24'h123456) begin bad++; $display("FAIL basic_hold got=%h want=123456", bus.bcd_out); end
  endtask

  task automatic test_small;
    int lat;
    do_conv(20'd0, lat);
    total++; if (lat != 21) begin bad++; $display("FAIL zero_latency got=%0d want=21", lat); end
    total++; if (bus.bcd_out !== 24'h000000) begin bad++; $display("FAIL zero_bcd got=%h want=000000", bus.bcd_out); end
    total++; if (bus.blank !== 6'b111110) begin bad++; $display("FAIL zero_blank got=%b want=111110", bus.blank); end
    do_conv(20'd7, lat);
    total++; if (bus.bcd_out !== 24'h000007) begin bad++; $display("FAIL seven_bcd got=%h want=000007", bus.bcd_out); end
    total++; if (bus.blank !== 6'b111110) begin bad++; $display("FAIL seven_blank got=%b want=111110", bus.blank); end
  endtask

  task automatic test_ovf;
    int lat;
    do_conv(20'd999999, lat);
    total++; if (bus.bcd_out !== 24'h999999) begin bad++; $display("FAIL max_bcd got=%h want=999999", bus.bcd_out); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL max_ovf got=%b want=0", bus.ovf); end
    total++; if (bus.blank !== 6'b000000) begin bad++; $display("FAIL max_blank got=%b want=000000", bus.blank); end
    do_conv(20'd1000000, lat);
    total++; if (bus.bcd_out !== 24'h999999) begin bad++; $display("FAIL ovf_bcd got=%h want=999999", bus.bcd_out); end
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", bus.ovf); end
    total++; if (bus.blank !== 6'b000000) begin bad++; $display("FAIL ovf_blank got=%b want=000000", bus.blank); end
  endtask

  task automatic test_ignore_busy_start;
    int ndone;
    int first;
    ndone = 0;
    first = -1;
    bus.start  = 1'b1;
    bus.bin_in = 20'd4096;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        bus.start  = 1'b1;
        bus.bin_in = 20'd55;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
    total++; if (first != 21) begin bad++; $display("FAIL ignore_latency got=%0d want=21", first); end
    total++; if (bus.bcd_out !== 24'h004096) begin bad++; $display("FAIL ignore_bcd got=%h want=004096", bus.bcd_out); end
    total++; if (bus.blank !== 6'b110000) begin bad++; $display("FAIL ignore_blank got=%b want=110000", bus.blank); end
  endtask

  task automatic test_reset_abort;
    int ndone;
    int lat;
    ndone = 0;
    bus.start  = 1'b1;
    bus.bin_in = 20'd654321;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", bus.done); end
    total++; if (bus.bcd_out !== 24'h000000) begin bad++; $display("FAIL abort_bcd got=%h want=000000", bus.bcd_out); end
    total++; if (bus.blank !== 6'b111110) begin bad++; $display("FAIL abort_blank got=%b want=111110", bus.blank); end
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
    do_conv(20'd42, lat);
    total++; if (lat != 21) begin bad++; $display("FAIL after_abort_latency got=%0d want=21", lat); end
    total++; if (bus.bcd_out !== 24'h000042) begin bad++; $display("FAIL after_abort_bcd got=%h want=000042", bus.bcd_out); end
  endtask

  task automatic test_back_to_back;
    int first;
    int second;
    first  = -1;
    second = -1;
    bus.start  = 1'b1;
    bus.bin_in = 20'd321;
    @(posedge clk); #1;
    bus.bin_in = 20'd58;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        first = c;
        break;
      end
    end
    total++; if (first != 21) begin bad++; $display("FAIL b2b_first_latency got=%0d want=21", first); end
    total++; if (bus.bcd_out !== 24'h000321) begin bad++; $display("FAIL b2b_first_bcd got=%h want=000321", bus.bcd_out); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%b want=1", bus.busy); end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        second = c;
        break;
      end
    end
    total++; if (second != 21) begin bad++; $display("FAIL b2b_second_latency got=%0d want=21", second); end
    total++; if (bus.bcd_out !== 24'h000058) begin bad++; $display("FAIL b2b_second_bcd got=%h want=000058", bus.bcd_out); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    test_reset();
    test_basic();
    test_small();
    test_ovf();
    test_ignore_busy_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
